// File: rtl/score_display_mux.sv
// score_display_mux
// Converts a 0-99 score into two decimal digits with an iterative
// subtract-by-ten converter, then drives a two-digit, time-multiplexed,
// common-cathode 7-segment display.
//
// Interface timing:
//   update_o is a one-cycle strobe. It is high in the cycle after the edge
//   that commits new digits. There is no back-pressure, and the consumer
//   is never asked to acknowledge. busy_o is high exactly while the
//   converter is in CONV, so it also serves as the visible FSM state.
module score_display_mux #(
   parameter int BW      = 7,
   parameter int MUX_DIV = 1000
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic [BW-1:0] value_i,
   input  logic          blank_lz_i,
   output logic [6:0]    seg_o,
   output logic [1:0]    dig_sel_o,
   output logic          busy_o,
   output logic          update_o
);

   // Width of the refresh counter. MUX_DIV is at least 2, so this is at least 1.
   localparam int RW = $clog2(MUX_DIV);
   localparam logic [RW-1:0] REF_MAX = RW'(MUX_DIV - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CONV = 1'b1
   } state_e;

   // Converter state
   state_e     state_q, state_d;
   logic [6:0] rem_q, rem_d;
   logic [3:0] tens_acc_q, tens_acc_d;
   logic [3:0] ones_q, ones_d;
   logic [3:0] tens_q, tens_d;
   logic       update_q, update_d;

   // Display multiplexing state. dig_q is 0 for the ones digit and 1 for tens.
   logic [RW-1:0] ref_cnt_q, ref_cnt_d;
   logic          dig_q, dig_d;
   logic [6:0]    seg_q, seg_d;
   logic [1:0]    dig_sel_q, dig_sel_d;

   logic [6:0] value_clamped;

   // Segment pattern for one decimal digit. Codes 10-15 cannot occur and
   // decode to all-off.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // Clamp out-of-range scores to 99 before they enter the converter.
   always_comb begin
      value_clamped = 7'd99;
      if (value_i <= BW'(99)) begin
         value_clamped = 7'(value_i);
      end
   end

   // Converter next-state logic. IDLE samples the input. CONV removes one ten
   // per cycle and commits once the remainder is a single digit.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      tens_acc_d = tens_acc_q;
      ones_d     = ones_q;
      tens_d     = tens_q;
      update_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rem_d      = value_clamped;
            tens_acc_d = 4'd0;
            state_d    = ST_CONV;
         end
         ST_CONV: begin
            if (rem_q >= 7'd10) begin
               rem_d      = rem_q - 7'd10;
               tens_acc_d = tens_acc_q + 4'd1;
            end else begin
               ones_d   = rem_q[3:0];
               tens_d   = tens_acc_q;
               update_d = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Refresh counter. The active digit toggles each time the counter wraps.
   always_comb begin
      ref_cnt_d = ref_cnt_q + RW'(1);
      dig_d     = dig_q;
      if (ref_cnt_q == REF_MAX) begin
         ref_cnt_d = '0;
         dig_d     = ~dig_q;
      end
   end

   // Segment and digit-enable values, registered together so they always agree.
   // The tens digit is blanked when leading-zero blanking is requested.
   always_comb begin
      dig_sel_d = 2'b01;
      seg_d     = seg_decode(ones_q);
      if (dig_q) begin
         dig_sel_d = 2'b10;
         seg_d     = seg_decode(tens_q);
         if (blank_lz_i && (tens_q == 4'd0)) begin
            seg_d = 7'h00;
         end
      end
   end

   // Converter registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         rem_q      <= 7'd0;
         tens_acc_q <= 4'd0;
         ones_q     <= 4'd0;
         tens_q     <= 4'd0;
         update_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         tens_acc_q <= tens_acc_d;
         ones_q     <= ones_d;
         tens_q     <= tens_d;
         update_q   <= update_d;
      end
   end

   // Display registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ref_cnt_q <= '0;
         dig_q     <= 1'b0;
         seg_q     <= 7'h00;
         dig_sel_q <= 2'b00;
      end else begin
         ref_cnt_q <= ref_cnt_d;
         dig_q     <= dig_d;
         seg_q     <= seg_d;
         dig_sel_q <= dig_sel_d;
      end
   end

   assign seg_o     = seg_q;
   assign dig_sel_o = dig_sel_q;
   assign busy_o    = (state_q == ST_CONV);
   assign update_o  = update_q;

endmodule

// File: tb/tb_score_display_mux.sv
// tb_score_display_mux
// Directed bench for score_display_mux with a cycle-level reference model.
// At each rising edge the model pushes the expected digit pair into exp_q
// when it samples a score. Each update_o pulse pops one entry, and that entry
// becomes the model's displayed digits. Every output is compared at every
// falling edge.
module tb_score_display_mux;

   localparam int BW      = 7;
   localparam int MUX_DIV = 4;

   logic          clk;
   logic          rst_n_i;
   logic [BW-1:0] value_i;
   logic          blank_lz_i;
   logic [6:0]    seg_o;
   logic [1:0]    dig_sel_o;
   logic          busy_o;
   logic          update_o;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [7:0] exp_q[$];
   logic [6:0] exp_seg;
   logic [1:0] exp_dig;
   logic       exp_upd;
   logic       m_busy;
   int         m_left;
   int         m_ref;
   logic       m_dig;
   logic [3:0] disp_ones;
   logic [3:0] disp_tens;

   score_display_mux #(
      .BW      (BW),
      .MUX_DIV (MUX_DIV)
   ) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n_i),
      .value_i    (value_i),
      .blank_lz_i (blank_lz_i),
      .seg_o      (seg_o),
      .dig_sel_o  (dig_sel_o),
      .busy_o     (busy_o),
      .update_o   (update_o)
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] table_v [10];
      table_v = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      return (d < 4'd10) ? table_v[d] : 7'h00;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_seg   = 7'h00;
      exp_dig   = 2'b00;
      exp_upd   = 1'b0;
      m_busy    = 1'b0;
      m_left    = 0;
      m_ref     = 0;
      m_dig     = 1'b0;
      disp_ones = 4'd0;
      disp_tens = 4'd0;
   endtask

   // Reference behaviour for one rising edge, using pre-edge model state.
   task automatic model_edge();
      int v;
      if (!rst_n_i) begin
         model_reset();
         return;
      end
      exp_dig = m_dig ? 2'b10 : 2'b01;
      if (m_dig) begin
         exp_seg = (blank_lz_i && disp_tens == 4'd0) ? 7'h00 : seg_of(disp_tens);
      end else begin
         exp_seg = seg_of(disp_ones);
      end
      if (m_ref == MUX_DIV - 1) begin
         m_ref = 0;
         m_dig = ~m_dig;
      end else begin
         m_ref++;
      end
      exp_upd = 1'b0;
      if (!m_busy) begin
         v = (int'(value_i) > 99) ? 99 : int'(value_i);
         exp_q.push_back({4'(v / 10), 4'(v % 10)});
         m_left = v / 10 + 1;
         m_busy = 1'b1;
      end else begin
         m_left--;
         if (m_left == 0) begin
            m_busy  = 1'b0;
            exp_upd = 1'b1;
         end
      end
   endtask

   // Compares all outputs. Pops the scoreboard when the DUT reports a commit.
   task automatic check_outputs();
      logic [7:0] d;
      if (!rst_n_i) model_reset();
      check("seg", {1'b0, seg_o}, {1'b0, exp_seg});
      check("dig_sel", {6'd0, dig_sel_o}, {6'd0, exp_dig});
      check("busy", {7'd0, busy_o}, {7'd0, m_busy});
      check("update", {7'd0, update_o}, {7'd0, exp_upd});
      if (update_o === 1'b1) begin
         check("sb_pending", {7'd0, exp_q.size() != 0}, 8'd1);
         if (exp_q.size() != 0) begin
            d         = exp_q.pop_front();
            disp_tens = d[7:4];
            disp_ones = d[3:0];
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
      #2;
   endtask

   // Ticks until the model has m_left == target during a conversion, within a cycle budget.
   task automatic wait_left(input int target, input string tag);
      int n;
      n = 0;
      while (!(m_busy && m_left == target) && n < 40) begin
         tick();
         n++;
      end
      check(tag, {7'd0, n < 40}, 8'd1);
      #2;
   endtask

   // Directed stimulus sequence
   initial begin
      rst_n_i    = 1'b0;
      value_i    = '0;
      blank_lz_i = 1'b0;
      model_reset();

      // Reset state
      run(3);
      rst_n_i = 1'b1;

      // Score 0: both digits show "0", update every 2 cycles
      run(20);

      // Score 47 held
      value_i = 7'd47;
      run(30);

      // Worst case, then clamp
      value_i = 7'd99;
      run(40);
      value_i = 7'd120;
      run(40);

      // Leading-zero blanking
      value_i    = 7'd5;
      blank_lz_i = 1'b1;
      run(24);
      blank_lz_i = 1'b0;
      run(16);

      // Input change in the middle of a conversion of 99
      value_i = 7'd99;
      wait_left(10, "sample_99");
      run(3);
      value_i = 7'd12;
      run(30);

      // Asynchronous reset in the middle of a conversion
      value_i = 7'd99;
      wait_left(5, "mid_conv");
      @(posedge clk);
      model_edge();
      #3;
      rst_n_i = 1'b0;
      #1;
      check("rst_seg", {1'b0, seg_o}, 8'h00);
      check("rst_dig_sel", {6'd0, dig_sel_o}, 8'h00);
      check("rst_busy", {7'd0, busy_o}, 8'h00);
      check("rst_update", {7'd0, update_o}, 8'h00);
      @(negedge clk);
      check_outputs();
      run(3);
      rst_n_i = 1'b1;
      run(30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
